// File: rtl/status_pkg.sv
// Shared types and default parameters for the status stretcher.
package status_pkg;

  typedef enum logic [1:0] {
    STRETCH = 2'b00,
    STICKY  = 2'b01,
    BLINK   = 2'b10,
    OFF     = 2'b11
  } mode_e;

  localparam int DEF_NUM_CH      = 16;
  localparam int DEF_TICK_PERIOD = 10_000_000 - 1;
  localparam int DEF_HOLD_TICKS  = 2;
  localparam int DEF_USE_EXT     = 0;

endpackage

// File: rtl/status_tick_gen.sv
// Free-running tick generator: one-clk pulse every TICK_PERIOD+1 clocks.
module status_tick_gen
  import status_pkg::*;
#(
  parameter int TICK_PERIOD = DEF_TICK_PERIOD
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_PERIOD < 1) ? 1 : $clog2(TICK_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD);

  logic [CW-1:0] cnt_q;

  // tick is registered so it is 0 in reset and first fires
  // TICK_PERIOD+1 clocks after release
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_q == LAST);
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/status_stretcher.sv
// Per-channel status LED driver: stretch, sticky, blink or off.
module status_stretcher
  import status_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int TICK_PERIOD  = DEF_TICK_PERIOD,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int USE_EXT_TICK = DEF_USE_EXT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   status,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   clr,
  input  logic                tick_in,
  output logic [NUM_CH-1:0]   led,
  output logic [NUM_CH-1:0]   pending,
  output logic                tick
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_TICKS);

  logic gen_tick;

  generate
    if (USE_EXT_TICK != 0) begin : g_ext
      assign gen_tick = 1'b0;
    end else begin : g_int
      status_tick_gen #(
        .TICK_PERIOD (TICK_PERIOD)
      ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (gen_tick)
      );
    end
  endgenerate

  assign tick = (USE_EXT_TICK != 0) ? tick_in : gen_tick;

  logic [HW-1:0]     cnt_q [NUM_CH];
  logic [HW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] latch_q, latch_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              phase_q, phase_d;

  // led is computed from next state so it appears one clk after status
  always_comb begin
    phase_d = phase_q ^ tick;
    latch_d = latch_q;
    led_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case (mode_e'(mode[2*i +: 2]))
        STRETCH: begin
          if (status[i])
            cnt_d[i] = HOLD;
          else if (tick && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - HW'(1);
          led_d[i] = (cnt_d[i] != '0);
        end
        STICKY: begin
          latch_d[i] = status[i] | (latch_q[i] & ~clr[i]);
          led_d[i]   = latch_d[i];
        end
        BLINK: begin
          latch_d[i] = status[i] | (latch_q[i] & ~clr[i]);
          led_d[i]   = latch_d[i] & phase_d;
        end
        OFF: begin
          cnt_d[i]   = '0;
          latch_d[i] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
      latch_q <= '0;
      led_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= cnt_d[i];
      latch_q <= latch_d;
      led_q   <= led_d;
      phase_q <= phase_d;
    end
  end

  assign led     = led_q;
  assign pending = latch_q;

endmodule

// File: tb/tb_status_stretcher.sv
// Directed bench: internal-tick instance plus an external-tick instance.
module tb_status_stretcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_status, m_clr, m_led, m_pend;
  logic [7:0] m_mode;
  logic       m_tick_in, m_tick;
  logic [3:0] e_status, e_clr, e_led, e_pend;
  logic [7:0] e_mode;
  logic       e_tick_in, e_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  status_stretcher #(
    .NUM_CH(4), .TICK_PERIOD(3), .HOLD_TICKS(2), .USE_EXT_TICK(0)
  ) u_main (
    .clk(clk), .reset(reset), .status(m_status), .mode(m_mode),
    .clr(m_clr), .tick_in(m_tick_in), .led(m_led),
    .pending(m_pend), .tick(m_tick)
  );

  status_stretcher #(
    .NUM_CH(4), .TICK_PERIOD(3), .HOLD_TICKS(2), .USE_EXT_TICK(1)
  ) u_ext (
    .clk(clk), .reset(reset), .status(e_status), .mode(e_mode),
    .clr(e_clr), .tick_in(e_tick_in), .led(e_led),
    .pending(e_pend), .tick(e_tick)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] st;
    logic [3:0] cl;
    logic [3:0] led;
    logic [3:0] pend;
    logic       tk;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // row r drives cycle r after release; expectations are for cycle r+1
    // ch0 STRETCH, ch1 STICKY, ch2 BLINK, ch3 OFF with status held high
    tbl = '{
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b0},
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b0},
      '{4'hA, 4'h0, 4'h2, 4'h2, 1'b0},
      '{4'hC, 4'h0, 4'h6, 4'h6, 1'b1},
      '{4'h8, 4'h0, 4'h2, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h2, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h2, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h2, 4'h6, 1'b1},
      '{4'h8, 4'h0, 4'h6, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h6, 4'h6, 1'b0},
      '{4'h9, 4'h0, 4'h7, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h7, 4'h6, 1'b1},
      '{4'h8, 4'h0, 4'h3, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h3, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h3, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h3, 4'h6, 1'b1},
      '{4'h8, 4'h0, 4'h6, 4'h6, 1'b0},
      '{4'h8, 4'h0, 4'h6, 4'h6, 1'b0},
      '{4'h8, 4'h4, 4'h2, 4'h2, 1'b0},
      '{4'h8, 4'h0, 4'h2, 4'h2, 1'b1},
      '{4'h8, 4'h0, 4'h2, 4'h2, 1'b0},
      '{4'h8, 4'h0, 4'h2, 4'h2, 1'b0},
      '{4'h8, 4'h2, 4'h0, 4'h0, 1'b0},
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b1}
    };

    reset     = 1'b1;
    m_status  = 4'h8;
    m_clr     = 4'h0;
    m_mode    = 8'hE4;
    m_tick_in = 1'b0;
    e_status  = 4'h0;
    e_clr     = 4'h0;
    e_mode    = 8'h00;
    e_tick_in = 1'b0;

    step();
    step();
    chk("reset_led", m_led, 4'h0);
    chk("reset_pend", m_pend, 4'h0);
    chk("reset_tick", m_tick, 1'b0);
    chk("reset_ext_led", e_led, 4'h0);
    chk("reset_ext_pend", e_pend, 4'h0);

    reset = 1'b0;
    for (int r = 0; r < 24; r++) begin
      m_status = tbl[r].st;
      m_clr    = tbl[r].cl;
      step();
      chk($sformatf("tbl_led_c%0d", r + 1), m_led, tbl[r].led);
      chk($sformatf("tbl_pend_c%0d", r + 1), m_pend, tbl[r].pend);
      chk($sformatf("tbl_tick_c%0d", r + 1), m_tick, tbl[r].tk);
    end

    // ch3 OFF -> STRETCH with status still high
    m_mode   = 8'h24;
    m_status = 4'hA;
    m_clr    = 4'h0;
    step();
    chk("off2stretch_led3", m_led[3], 1'b1);
    chk("sticky_set_pend1", m_pend[1], 1'b1);

    m_clr = 4'h2;
    step();
    chk("status_wins_pend1", m_pend[1], 1'b1);
    chk("status_wins_led1", m_led[1], 1'b1);

    m_status = 4'h8;
    m_clr    = 4'h0;
    step();
    chk("sticky_hold_pend1", m_pend[1], 1'b1);

    m_clr = 4'h2;
    step();
    chk("sticky_clr_pend1", m_pend[1], 1'b0);
    chk("sticky_clr_led1", m_led[1], 1'b0);

    // status held through the tick at 28, falls at 30; ticks at 32, 36
    for (int c = 28; c < 37; c++) begin
      m_clr    = 4'h0;
      m_status = (c < 30) ? 4'h8 : 4'h0;
      step();
      chk($sformatf("hold_led3_c%0d", c + 1), m_led[3], (c + 1 <= 36));
    end
    chk("stretch_no_latch3", m_pend[3], 1'b0);

    step();
    m_status = 4'h3;
    step();
    chk("pre_reset_led0", m_led[0], 1'b1);
    chk("pre_reset_pend1", m_pend[1], 1'b1);

    // reset lands on the cycle a tick would otherwise appear
    reset    = 1'b1;
    m_status = 4'h0;
    step();
    chk("mid_reset_led", m_led, 4'h0);
    chk("mid_reset_pend", m_pend, 4'h0);
    chk("mid_reset_tick", m_tick, 1'b0);

    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("first_tick_k%0d", k), m_tick, (k == 4));
    end
    chk("post_reset_pend", m_pend, 4'h0);

    // external tick every 7 clocks; stretch decrements only on tick_in
    for (int k = 0; k < 16; k++) begin
      e_status  = (k == 0) ? 4'h1 : 4'h0;
      e_tick_in = (k % 7 == 6);
      #1;
      chk($sformatf("ext_tick_k%0d", k), e_tick, (k % 7 == 6));
      step();
      chk($sformatf("ext_led0_k%0d", k + 1), e_led[0], (k + 1 <= 13));
    end
    e_tick_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
